// File: rtl/acc64_seq.sv
// Sequential accumulator: sums a programmed number of operand beats (each with its
// own carry-in) and hands the final sum, carry and sticky overflow to a consumer.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the previous run's result
// ACC    | accepting operand beats until rem reaches zero
// DONE   | result presented, waiting for out_ready
module acc64_seq #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_cin,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic [WIDTH:0]   sum_full;

   // The accumulator itself is the adder's first operand; the carry-out is only reported.
   assign sum_full = {1'b0, out_sum} + {1'b0, in_data} + (WIDTH+1)'(in_cin);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rem       <= '0;
         out_sum   <= '0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
         out_cnt   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  out_sum   <= '0;
                  out_carry <= 1'b0;
                  out_ovf   <= 1'b0;
                  out_cnt   <= '0;
                  rem       <= len;
                  busy      <= 1'b1;
                  if (len != '0) begin
                     state    <= S_ACC;
                     in_ready <= 1'b1;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_ACC: begin
               if (in_valid) begin
                  out_sum   <= sum_full[WIDTH-1:0];
                  out_carry <= sum_full[WIDTH];
                  out_ovf   <= out_ovf | sum_full[WIDTH];
                  out_cnt   <= out_cnt + 1'b1;
                  rem       <= rem - 1'b1;
                  if (rem == CNT_W'(1)) begin
                     state     <= S_DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc64_seq.sv
// Scoreboard bench for acc64_seq: a reference model predicts each run's result at
// stimulus time; the result is popped and compared when out_valid is observed.
module tb_acc64_seq;
   localparam int WIDTH = 64;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_cin = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             out_ovf;
   logic [CNT_W-1:0] out_cnt;
   logic             busy;

   acc64_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_cin(in_cin), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_carry(out_carry), .out_ovf(out_ovf), .out_cnt(out_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
      logic [CNT_W-1:0] cnt;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [WIDTH-1:0] m_sum;
   logic             m_carry;
   logic             m_ovf;
   logic [CNT_W-1:0] m_cnt;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int n);
      start = 1'b1;
      len   = n[CNT_W-1:0];
      tick;
      start = 1'b0;
      m_sum = '0; m_carry = 1'b0; m_ovf = 1'b0; m_cnt = '0;
      chk("busy_after_start", {63'd0, busy}, 1);
      if (n != 0) chk("in_ready_after_start", {63'd0, in_ready}, 1);
   endtask

   task automatic send_beat(input logic [WIDTH-1:0] d, input logic c, input int gap);
      logic [WIDTH:0] full;
      int k;
      in_valid = 1'b0;
      repeat (gap) tick;
      in_valid = 1'b1;
      in_data  = d;
      in_cin   = c;
      k = 0;
      while (!in_ready && k < 50) begin
         tick;
         k++;
      end
      if (k == 50) chk("in_ready_timeout", {63'd0, in_ready}, 1);
      tick;
      in_valid = 1'b0;
      full    = {1'b0, m_sum} + {1'b0, d} + {{WIDTH{1'b0}}, c};
      m_sum   = full[WIDTH-1:0];
      m_carry = full[WIDTH];
      m_ovf   = m_ovf | full[WIDTH];
      m_cnt   = m_cnt + 1'b1;
   endtask

   task automatic push_exp;
      res_t r;
      r.sum = m_sum; r.carry = m_carry; r.ovf = m_ovf; r.cnt = m_cnt;
      exp_q.push_back(r);
   endtask

   task automatic collect(input int stall);
      res_t r;
      chk("out_valid_latency", {63'd0, out_valid}, 1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 64'(exp_q.size()), 1);
         return;
      end
      r = exp_q.pop_front();
      chk("out_sum", out_sum, r.sum);
      chk("out_carry", {63'd0, out_carry}, {63'd0, r.carry});
      chk("out_ovf", {63'd0, out_ovf}, {63'd0, r.ovf});
      chk("out_cnt", {56'd0, out_cnt}, {56'd0, r.cnt});
      for (int i = 0; i < stall; i++) begin
         tick;
         chk("stall_valid", {63'd0, out_valid}, 1);
         chk("stall_sum", out_sum, r.sum);
         chk("stall_cnt", {56'd0, out_cnt}, {56'd0, r.cnt});
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("idle_out_valid", {63'd0, out_valid}, 0);
      chk("idle_busy", {63'd0, busy}, 0);
      chk("idle_in_ready", {63'd0, in_ready}, 0);
      chk("held_sum", out_sum, r.sum);
   endtask

   task automatic check_cleared;
      chk("rst_sum", out_sum, 0);
      chk("rst_carry", {63'd0, out_carry}, 0);
      chk("rst_ovf", {63'd0, out_ovf}, 0);
      chk("rst_cnt", {56'd0, out_cnt}, 0);
      chk("rst_out_valid", {63'd0, out_valid}, 0);
      chk("rst_in_ready", {63'd0, in_ready}, 0);
      chk("rst_busy", {63'd0, busy}, 0);
   endtask

   initial begin
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      check_cleared;

      // single beat with carry-in
      start_run(1);
      send_beat(64'd5, 1'b1, 0);
      push_exp;
      collect(0);

      // carry-out on final add
      start_run(2);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
      send_beat(64'd1, 1'b0, 0);
      push_exp;
      collect(0);

      // carry on first add only: sticky ovf, last carry clear
      start_run(2);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
      send_beat(64'd0, 1'b0, 0);
      push_exp;
      chk("ovf_sticky_model", {63'd0, m_ovf & ~m_carry}, 1);
      collect(0);

      // gapped input and stalled output
      start_run(3);
      send_beat(64'd10, 1'b0, 0);
      send_beat(64'd20, 1'b0, 1);
      send_beat(64'd30, 1'b0, 1);
      push_exp;
      collect(4);

      // zero-length run
      start_run(0);
      push_exp;
      collect(0);

      // start pulse during ACC is ignored
      start_run(2);
      send_beat(64'd3, 1'b0, 0);
      start = 1'b1;
      len   = 8'd7;
      tick;
      start = 1'b0;
      chk("start_ignored_busy", {63'd0, in_ready}, 1);
      send_beat(64'd4, 1'b0, 0);
      push_exp;
      collect(0);

      // reset mid-run drops the beat presented with it
      start_run(3);
      send_beat(64'd7, 1'b0, 0);
      chk("pre_rst_sum", out_sum, 7);
      in_valid = 1'b1;
      in_data  = 64'd100;
      rst      = 1'b1;
      tick;
      rst      = 1'b0;
      in_valid = 1'b0;
      check_cleared;
      start_run(1);
      send_beat(64'd9, 1'b0, 0);
      push_exp;
      collect(0);

      // back-to-back runs: start immediately after handshake
      start_run(2);
      send_beat(64'd11, 1'b0, 0);
      send_beat(64'd22, 1'b1, 0);
      push_exp;
      collect(0);
      start_run(2);
      send_beat(64'd33, 1'b0, 0);
      send_beat(64'd44, 1'b0, 0);
      push_exp;
      collect(0);

      // 200 random beats with random gaps
      start_run(200);
      for (int i = 0; i < 200; i++)
         send_beat({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      push_exp;
      collect(1);

      // maximum length: count must reach 255 without wrapping
      start_run(255);
      for (int i = 0; i < 255; i++)
         send_beat({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0);
      push_exp;
      chk("max_cnt_model", {56'd0, m_cnt}, 255);
      collect(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc64_seq.md
# acc64_seq

Sequential 64-bit accumulator downstream of the 64-bit ripple-carry adder. It takes a stream of operands with per-operand carry-in and feeds its running sum back as the adder's first operand. After a programmed number of operands it presents the final sum, final carry and a sticky overflow flag through a valid/ready output handshake.

## Interface
- WIDTH, 64, operand/accumulator width
- CNT_W, 8, width of operand-count field

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new accumulation; sampled only in IDLE
- len  in  CNT_W  number of operands to accumulate; sampled with start
- in_valid  in  1  operand beat valid
- in_data  in  WIDTH  operand
- in_cin  in  1  carry-in for this operand's add
- in_ready  out  1  block accepts an operand this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_sum  out  WIDTH  accumulated sum, mod 2^WIDTH
- out_carry  out  1  carry-out of the last add
- out_ovf  out  1  OR of carry-out over all adds in this run
- out_cnt  out  CNT_W  operands accepted in this run
- busy  out  1  high in ACC and DONE

## Operation
- One clock; reset is synchronous and active-high.
- States: IDLE, ACC, DONE.
- IDLE: in_ready=0, out_valid=0, busy=0.
  - start=1, len≠0: acc←0, carry←0, ovf←0, cnt←0, rem←len; go to ACC.
  - start=1, len=0: acc←0, flags←0, cnt←0; go directly to DONE.
- ACC: in_ready=1. On in_valid&in_ready:
  - {c, acc} ← acc + in_data + in_cin, computed as a full WIDTH+1-bit sum.
  - carry←c; ovf←ovf|c; cnt←cnt+1; rem←rem−1.
  - If rem==1 before the decrement, go to DONE.
  - If in_valid=0, hold all state.
- DONE: out_valid=1. out_sum, out_carry, out_ovf and out_cnt are stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE. Output registers keep their last values; only out_valid drops.
- start is ignored in ACC and DONE. len is not re-sampled.
- Arithmetic wraps mod 2^WIDTH. Carry-out is never added back into acc.
- in_cin applies only to its own beat. No carry chains between beats except through out_carry/out_ovf reporting.
- Reset at any time, including mid-ACC or in DONE with out_valid high:
  - next state IDLE.
  - out_sum=0, out_carry=0, out_ovf=0, out_cnt=0, out_valid=0, in_ready=0, busy=0.
  - A beat presented in the reset cycle is dropped.

## Timing
- in_ready and out_valid are decoded directly from registered state. There is no combinational path from in_valid or out_ready to any output.
- Start to first accept: start sampled in cycle t; in_ready=1 from t+1.
- Last accepted beat in cycle t: out_valid=1 at t+1, carrying the sum including that beat.
- Full-rate throughput: len beats take len cycles in ACC. A run with no stalls occupies 1+len+1 cycles, start to IDLE.
- len=0: out_valid=1 the cycle after start, with out_sum=0 and out_cnt=0.
- Handshake on out_valid&out_ready at t: IDLE at t+1. A new start is accepted at t+1 at the earliest.
- len=2^CNT_W−1 is a legal maximum; out_cnt must not wrap.

## Test plan
- Reset, then start with len=1 and beat data=5, cin=1 → out_valid one cycle later; out_sum=6, out_carry=0, out_ovf=0, out_cnt=1.
- len=2, beats 0xFFFF_FFFF_FFFF_FFFF (cin=0) then 0x1 (cin=0) → out_sum=0, out_carry=1, out_ovf=1, out_cnt=2. Then len=2, beats 0xFFFF_FFFF_FFFF_FFFF (cin=1) then 0x0 (cin=0) → out_sum=0, out_carry=0, out_ovf=1.
- len=3, beats 10, 20, 30 with in_valid low on alternate cycles and out_ready held low 4 cycles → out_sum=60, out_cnt=3, outputs stable while stalled, IDLE one cycle after out_ready=1.
- len=0 → out_valid the cycle after start, out_sum=0, out_cnt=0. A start pulse during ACC of a len=2 run → ignored; run completes with cnt=2.
- Reset asserted after 1 of 3 beats (sum=7) → next cycle all outputs 0 and busy=0. A fresh len=1 run with data=9 → out_sum=9.
- Back-to-back runs, start asserted the cycle after the output handshake → second run accepted with no lost beats. 200 random (data, cin) beats with len=200 → out_sum and out_ovf match a reference model.
